// File: rtl/data_memory_sized.sv
// Word-organised data memory with byte/half/word access, sweep clear FSM and test tap.
// Optional suppressed-store counter on err_count is built when DMEM_ERR_CNT_EN is defined.
module data_memory_sized #(
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 32,
    parameter int TEST_WORD = 0
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [ADDR_W-1:0] A,
    input  logic [31:0]       WD,
    input  logic              WE,
    input  logic [1:0]        SIZE,
    input  logic              SIGNED,
    input  logic              clr_req,
    output logic [31:0]       RD,
    output logic              busy,
    output logic              misaligned,
    output logic              oob,
    output logic [15:0]       test_value,
    output logic [7:0]        err_count
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [31:0]       mem_q [DEPTH];
    logic [15:0]       test_value_q;

    logic [IDX_W-1:0]  word_idx_s;
    logic [ADDR_W-1:0] word_addr_s;
    logic              misaligned_s, oob_s, busy_s, store_ok_s;
    logic              wen_s;
    logic [IDX_W-1:0]  widx_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s, rd_word_s, rd_s;
    logic [7:0]        rd_byte_s;
    logic [15:0]       rd_half_s;

    assign word_idx_s  = A[IDX_W+1:2];
    assign word_addr_s = A >> 2;
    assign busy_s      = (state_q == ST_CLEAR);
    // A clear request in the same cycle as a store always wins.
    assign store_ok_s  = (state_q == ST_READY) & WE & ~misaligned_s & ~oob_s & ~clr_req;

    // Alignment and range checks depend only on address and size.
    always_comb begin
        case (SIZE)
            2'b00:   misaligned_s = 1'b0;
            2'b01:   misaligned_s = A[0];
            default: misaligned_s = (A[1:0] != 2'b00);
        endcase
        oob_s = (word_addr_s >= ADDR_W'(DEPTH));
    end

    // Sweep FSM next-state logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_req) begin
                    idx_d = {IDX_W{1'b0}};
                end else if (idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_READY: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    idx_d   = {IDX_W{1'b0}};
                end else begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Sweep FSM state registers.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            idx_q   <= {IDX_W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Single write port shared by the sweep and lane-masked stores.
    always_comb begin
        wen_s   = 1'b0;
        widx_s  = word_idx_s;
        be_s    = 4'h0;
        wdata_s = 32'h0000_0000;
        if (busy_s && !reset) begin
            wen_s  = 1'b1;
            widx_s = idx_q;
            be_s   = 4'hF;
        end else if (store_ok_s) begin
            wen_s = 1'b1;
            case (SIZE)
                2'b00: begin
                    be_s    = 4'b0001 << A[1:0];
                    wdata_s = {4{WD[7:0]}};
                end
                2'b01: begin
                    be_s    = A[1] ? 4'b1100 : 4'b0011;
                    wdata_s = {2{WD[15:0]}};
                end
                default: begin
                    be_s    = 4'hF;
                    wdata_s = WD;
                end
            endcase
        end else begin
            wen_s = 1'b0;
        end
    end

    // Storage array, no reset: zeroing is done by the sweep.
    always_ff @(posedge CLK) begin
        if (wen_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_q[widx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
        end
    end

    // Combinational load path with lane select and extension.
    always_comb begin
        rd_word_s = mem_q[word_idx_s];
        rd_byte_s = rd_word_s[8*A[1:0] +: 8];
        rd_half_s = A[1] ? rd_word_s[31:16] : rd_word_s[15:0];
        if (busy_s || misaligned_s || oob_s) begin
            rd_s = 32'h0000_0000;
        end else begin
            case (SIZE)
                2'b00:   rd_s = SIGNED ? {{24{rd_byte_s[7]}}, rd_byte_s} : {24'h00_0000, rd_byte_s};
                2'b01:   rd_s = SIGNED ? {{16{rd_half_s[15]}}, rd_half_s} : {16'h0000, rd_half_s};
                default: rd_s = rd_word_s;
            endcase
        end
    end

    // Test tap: one edge behind the array contents.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            test_value_q <= 16'h0000;
        end else begin
            test_value_q <= mem_q[TEST_WORD][15:0];
        end
    end

`ifdef DMEM_ERR_CNT_EN
    logic [7:0] err_q, err_d;

    // Saturating count of stores dropped for alignment or range.
    always_comb begin
        err_d = err_q;
        if (clr_req) begin
            err_d = 8'h00;
        end else if ((state_q == ST_READY) && WE && (misaligned_s || oob_s) && (err_q != 8'hFF)) begin
            err_d = err_q + 8'h01;
        end else begin
            err_d = err_q;
        end
    end

    // Error counter register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            err_q <= 8'h00;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 8'h00;
`endif

    assign RD         = rd_s;
    assign busy       = busy_s;
    assign misaligned = misaligned_s;
    assign oob        = oob_s;
    assign test_value = test_value_q;

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: byte-addressed reference model, queue-decoupled monitor.
module tb_data_memory_sized;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 32;
    localparam int TW     = 2;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] A = 32'h0;
    logic [31:0] WD = 32'h0;
    logic        WE = 1'b0;
    logic [1:0]  SIZE = 2'b00;
    logic        SIGNED = 1'b0;
    logic        clr_req = 1'b0;
    logic [31:0] RD;
    logic        busy, misaligned, oob;
    logic [15:0] test_value;
    logic [7:0]  err_count;

    data_memory_sized #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TEST_WORD(TW)) dut (
        .CLK(CLK), .reset(reset), .A(A), .WD(WD), .WE(WE), .SIZE(SIZE),
        .SIGNED(SIGNED), .clr_req(clr_req), .RD(RD), .busy(busy),
        .misaligned(misaligned), .oob(oob), .test_value(test_value), .err_count(err_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: flat byte memory plus sweep countdown.
    bit [7:0]  ref_bytes [DEPTH*4];
    bit        word_known [DEPTH];
    int        clear_left = DEPTH;
    bit [15:0] ref_tv = 16'h0;
    bit        tv_known = 1'b1;
    int        ref_err = 0;
    bit        in_reset = 1'b1;

    function automatic bit f_mis(logic [31:0] a, logic [1:0] s);
        return (s == 2'd1 && a[0]) || (s[1] && a[1:0] != 2'd0);
    endfunction

    function automatic bit f_oob(logic [31:0] a);
        return (a >> 2) >= 32'(DEPTH);
    endfunction

    function automatic int f_nbytes(logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] f_load(logic [31:0] a, logic [1:0] s, logic sg);
        logic [31:0] v;
        int n;
        v = 32'h0;
        if (in_reset || clear_left > 0 || f_mis(a, s) || f_oob(a)) return 32'h0;
        n = f_nbytes(s);
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[int'(a) + i]) << (8 * i));
        if (sg && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
        return v;
    endfunction

    function automatic logic [31:0] actual(int kind);
        case (kind)
            0:       return RD;
            1:       return {31'h0, busy};
            2:       return {31'h0, misaligned};
            3:       return {31'h0, oob};
            4:       return {16'h0, test_value};
            default: return {24'h0, err_count};
        endcase
    endfunction

    task automatic push(input int kind, input logic [31:0] e, input string nm);
        chk_t c;
        c.kind = kind;
        c.exp  = e;
        c.name = nm;
        exp_q.push_back(c);
    endtask

    task automatic push_model();
        push(0, f_load(A, SIZE, SIGNED), "rd");
        push(1, {31'h0, (in_reset || clear_left > 0)}, "busy");
        push(2, {31'h0, f_mis(A, SIZE)}, "misaligned");
        push(3, {31'h0, f_oob(A)}, "oob");
        if (tv_known) push(4, {16'h0, ref_tv}, "test_value");
        push(5, 32'(ref_err), "err_count");
    endtask

    task automatic model_edge();
        bit        ready_pre, bad, nk;
        bit [15:0] ntv;
        int        w;
        if (in_reset) return;
        ready_pre = (clear_left == 0);
        bad = f_mis(A, SIZE) || f_oob(A);
        nk  = word_known[TW];
        ntv = {ref_bytes[TW*4+1], ref_bytes[TW*4]};
        if (!ready_pre) begin
            w = DEPTH - clear_left;
            for (int i = 0; i < 4; i++) ref_bytes[w*4 + i] = 8'h00;
            word_known[w] = 1'b1;
            clear_left = clr_req ? DEPTH : clear_left - 1;
        end else if (clr_req) begin
            clear_left = DEPTH;
        end else if (WE && !bad) begin
            for (int i = 0; i < f_nbytes(SIZE); i++) ref_bytes[int'(A) + i] = WD[8*i +: 8];
        end
`ifdef DMEM_ERR_CNT_EN
        if (clr_req) ref_err = 0;
        else if (ready_pre && WE && bad && ref_err < 255) ref_err = ref_err + 1;
`endif
        ref_tv   = ntv;
        tv_known = nk;
    endtask

    // Monitor: compare every queued expectation against the outputs mid-cycle.
    always @(negedge CLK) begin
        chk_t c;
        logic [31:0] act;
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            act = actual(c.kind);
            checks++;
            if (act !== c.exp) begin
                errors++;
                $display("FAIL %s at %0t: got %h expected %h (A=%h SIZE=%0d)", c.name, $time, act, c.exp, A, SIZE);
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic we,
                         input logic [1:0] sz, input logic sg, input logic clr);
        A = a; WD = wd; WE = we; SIZE = sz; SIGNED = sg; clr_req = clr;
    endtask

    task automatic tick();
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic we,
                        input logic [1:0] sz, input logic sg, input logic clr);
        drive(a, wd, we, sz, sg, clr);
        push_model();
        tick();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        in_reset = 1'b1;
        clear_left = DEPTH;
        ref_tv = 16'h0;
        tv_known = 1'b1;
        ref_err = 0;
        drive(32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);
        repeat (n) begin
            push_model();
            tick();
        end
        reset = 1'b0;
        in_reset = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        #1;
        do_reset(3);
        // Partial sweep, then reset in the middle (idx = 100).
        repeat (100) step(32'h3FC, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);
        do_reset(2);
        repeat (258) step(32'h3FC, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);

        step(32'h10, 32'hDEADBEEF, 1'b1, 2'd2, 1'b0, 1'b0);
        step(32'h11, 32'h00000055, 1'b1, 2'd0, 1'b0, 1'b0);
        drive(32'h10, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0); push_model(); push(0, 32'hDEAD55EF, "word_merge"); tick();
        drive(32'h13, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0); push_model(); push(0, 32'hFFFFFFDE, "byte_sext"); tick();
        drive(32'h13, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0); push_model(); push(0, 32'h000000DE, "byte_zext"); tick();

        step(32'h20, 32'hCAFEF00D, 1'b1, 2'd2, 1'b0, 1'b0);
        drive(32'h21, 32'h00001234, 1'b1, 2'd1, 1'b0, 1'b0); push_model(); push(2, 32'h1, "half_mis"); tick();
        drive(32'h20, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0); push_model(); push(0, 32'hCAFEF00D, "mis_no_write"); tick();
        step(32'h22, 32'h0, 1'b0, 2'd1, 1'b1, 1'b0);

        drive(32'h400, 32'h12345678, 1'b1, 2'd2, 1'b0, 1'b0); push_model(); push(3, 32'h1, "oob_flag"); push(0, 32'h0, "oob_rd"); tick();
        step(32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);
        for (int i = 0; i < 256; i++) step(32'h400 + 32'($urandom_range(0, 4095)), $urandom, 1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0);

        step(32'h08, 32'h0000ABCD, 1'b1, 2'd2, 1'b0, 1'b0);
        repeat (3) step(32'h08, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);

        step(32'h0, 32'h00000077, 1'b1, 2'd2, 1'b0, 1'b0);
        step(32'h0, 32'h11111111, 1'b1, 2'd2, 1'b0, 1'b1);
        repeat (257) step(32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            ra = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH*4 - 1));
            step(ra, $urandom, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
        end

        drive(32'h0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0);
        @(negedge CLK);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
